exe_stage: RTL and testbench
============================

Name: exe_stage

Overview:
- Execute stage of the 5-stage LoongArch pipeline, directly downstream of the decode stage.
- Latches the decode bus and computes ALU, multiply and divide results; the divider is iterative and multi-cycle.
- Issues the data-SRAM request for loads and stores, and returns forwarding and load-use information to decode.
- Hands results to the memory stage over a valid/allowin handshake.

Parameters:
DS_TO_ES_BUS_WD, 164, width of decode-to-execute bus
ES_TO_MS_BUS_WD, 78, width of execute-to-memory bus

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
ms_allowin  in  1  memory stage can accept
es_allowin  out  1  execute stage can accept
ds_to_es_valid  in  1  decode output valid
ds_to_es_bus  in  164  [162:155] ld_st_op{st_w,st_h,st_b,ld_w,ld_hu,ld_h,ld_bu,ld_b}; [154:148] mul_div_op{mod_wu,div_wu,mod_w,div_w,mulh_wu,mulh_w,mul_w}; [147:116] pc; [115:104] alu_op; [103:72] src1; [71:40] src2; [39:8] rkd_value; [7] res_from_mem; [6] mem_we; [5:1] dest; [0] gr_we; bit 163 unused (0)
es_to_ms_valid  out  1  result valid to memory stage
es_to_ms_bus  out  78  [77:73] ld_op{ld_w,ld_hu,ld_h,ld_bu,ld_b}; [72:71] addr[1:0]; [70] res_from_mem; [69] gr_we; [68:64] dest; [63:32] result; [31:0] pc
es_to_ds_dest  out  5  dest if es_valid & gr_we, else 0
es_to_ds_value  out  32  final result, for forwarding
es_value_from_mem  out  1  es_valid & res_from_mem
data_sram_en  out  1  memory request enable
data_sram_we  out  4  byte write enables
data_sram_addr  out  32  byte address (ALU sum)
data_sram_wdata  out  32  replicated store data

Behaviour:
- Pipeline control:
  - es_valid is cleared by reset; otherwise, when es_allowin, es_valid <= ds_to_es_valid.
  - The bus register loads when ds_to_es_valid & es_allowin.
  - es_allowin = !es_valid | (es_ready_go & ms_allowin).
  - es_to_ms_valid = es_valid & es_ready_go.
  - es_ready_go = 1, except for divide ops, where it is 1 only in div state DONE.
- ALU: the existing alu module is instantiated on alu_op/src1/src2. Its sum is the load/store address.
- Multiply, single cycle (33x33 signed product on sign/zero-extended src1, src2):
  - mul_w = low 32 bits of the signed product.
  - mulh_w = high 32 bits of the signed product.
  - mulh_wu = high 32 bits of the unsigned product.
- Divider FSM, states IDLE, BUSY, DONE:
  - IDLE -> BUSY when es_valid & any div/mod op. At that transition, |src1| and |src2| (signed ops) or raw values (unsigned ops) are captured, count = 0, and the quotient and sign flags are latched.
  - BUSY: one restoring-division step per cycle, 32 steps in total. Count 31 -> DONE.
  - DONE: es_ready_go = 1. DONE -> IDLE on es_to_ms_valid & ms_allowin. DONE holds while ms_allowin = 0.
  - Total latency: a divide occupies the stage for 34 cycles (1 IDLE + 32 BUSY + 1 DONE) with ms_allowin = 1.
- Divide sign fix-up:
  - Quotient is negated if the operand signs differ (signed ops only).
  - Remainder takes the sign of the dividend.
- Divide boundary cases:
  - Divide by zero: quotient 0xFFFFFFFF, remainder = src1. No exception.
  - 0x80000000 / -1 (signed): quotient 0x80000000, remainder 0.
- Result select: div/mod result if a div op, else mul result if a mul op, else ALU result.
- Memory request:
  - data_sram_en = es_valid & (res_from_mem | mem_we).
  - data_sram_we is 0 unless es_valid & mem_we.
  - st_w: we = 1111, wdata = rkd.
  - st_h: we = addr[1] ? 1100 : 0011, wdata = {2{rkd[15:0]}}.
  - st_b: we = 0001 << addr[1:0], wdata = {4{rkd[7:0]}}.
  - Misaligned addresses raise no exception; low address bits pass through.
  - The request may repeat while stalled; repeats are idempotent.
- Forwarding: es_to_ds_value is valid once es_ready_go is high. Decode cannot advance before then, because es_allowin is low.
- Reset mid-operation: es_valid -> 0, div FSM -> IDLE, count -> 0. The partial result is discarded.
- Reset values: es_to_ms_valid 0, es_allowin 1, es_to_ds_dest 0, es_value_from_mem 0, data_sram_en 0, data_sram_we 0.

Test Plan:
- add.w, src1 = 5, src2 = 7, ms_allowin = 1 -> result 12 on es_to_ms_bus the next cycle; es_to_ds_dest = dest.
- mulh_w, 0xFFFFFFFF x 0xFFFFFFFF -> result 0x00000000; mulh_wu with the same operands -> 0xFFFFFFFE.
- div_w, -7 / 2 -> quotient 0xFFFFFFFD after exactly 34 cycles; mod_w with the same operands -> 0xFFFFFFFF; es_allowin low throughout BUSY.
- div_wu by 0, src1 = 0x1234 -> quotient 0xFFFFFFFF; mod_wu -> 0x1234. div_w 0x80000000 / 0xFFFFFFFF -> 0x80000000.
- st_b at addr 0x1003, rkd = 0xAB -> we = 1000, wdata = 0xABABABAB. st_h at 0x1002 -> we = 1100. ld_w -> en = 1, we = 0, es_value_from_mem = 1.
- Divide in DONE with ms_allowin = 0 for 5 cycles -> result held and FSM stays in DONE. Reset asserted mid-BUSY -> es_valid = 0, FSM IDLE; the next divide completes correctly.

Source files
------------

// File: rtl/exe_stage.sv
// +--------------------------------------------------------------------------+
// | exe_stage : LoongArch execute stage (ALU, mul, iterative div, SRAM req)  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module exe_stage #(
  parameter int DS_TO_ES_BUS_WD = 164,
  parameter int ES_TO_MS_BUS_WD = 78
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ms_allowin,
  output logic                       es_allowin,
  input  logic                       ds_to_es_valid,
  input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
  output logic                       es_to_ms_valid,
  output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic [4:0]                 es_to_ds_dest,
  output logic [31:0]                es_to_ds_value,
  output logic                       es_value_from_mem,
  output logic                       data_sram_en,
  output logic [3:0]                 data_sram_we,
  output logic [31:0]                data_sram_addr,
  output logic [31:0]                data_sram_wdata
);

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  logic                       es_valid_q, es_valid_d;
  logic [DS_TO_ES_BUS_WD-1:0] bus_q, bus_d;
  div_state_e                 div_state_q, div_state_d;
  logic [4:0]                 div_cnt_q, div_cnt_d;
  logic [31:0]                div_rem_q, div_rem_d;
  logic [31:0]                div_quo_q, div_quo_d;
  logic [31:0]                div_dvs_q, div_dvs_d;
  logic                       div_qneg_q, div_qneg_d;
  logic                       div_rneg_q, div_rneg_d;

  logic [7:0]  ld_st_op;
  logic [6:0]  md_op;
  logic [31:0] pc, src1, src2, rkd;
  logic [11:0] alu_op;
  logic [4:0]  dest;
  logic        res_from_mem, mem_we, gr_we;

  assign ld_st_op     = bus_q[162:155];
  assign md_op        = bus_q[154:148];
  assign pc           = bus_q[147:116];
  assign alu_op       = bus_q[115:104];
  assign src1         = bus_q[103:72];
  assign src2         = bus_q[71:40];
  assign rkd          = bus_q[39:8];
  assign res_from_mem = bus_q[7];
  assign mem_we       = bus_q[6];
  assign dest         = bus_q[5:1];
  assign gr_we        = bus_q[0];

  logic is_div, is_signed_div, is_quo, is_mul, es_ready_go;
  assign is_div        = |md_op[6:3];
  assign is_signed_div = md_op[3] | md_op[4];
  assign is_quo        = md_op[3] | md_op[5];
  assign is_mul        = |md_op[2:0];

  assign es_ready_go    = !is_div || (div_state_q == DIV_DONE);
  assign es_allowin     = !es_valid_q || (es_ready_go && ms_allowin);
  assign es_to_ms_valid = es_valid_q && es_ready_go;

  always_comb begin
    es_valid_d = es_valid_q;
    bus_d      = bus_q;
    if (es_allowin) es_valid_d = ds_to_es_valid;
    if (ds_to_es_valid && es_allowin) bus_d = ds_to_es_bus;
  end

  logic [31:0] alu_result;
  alu u_alu (
    .alu_op     (alu_op),
    .alu_src1   (src1),
    .alu_src2   (src2),
    .alu_result (alu_result)
  );

  // 66-bit product of sign/zero-extended operands; low 64 bits are exact
  logic        mul_ext1, mul_ext2;
  logic [65:0] mul_a, mul_b, mul_prod;
  logic [31:0] mul_result;
  assign mul_ext1   = md_op[2] ? 1'b0 : src1[31];
  assign mul_ext2   = md_op[2] ? 1'b0 : src2[31];
  assign mul_a      = {{34{mul_ext1}}, src1};
  assign mul_b      = {{34{mul_ext2}}, src2};
  assign mul_prod   = mul_a * mul_b;
  assign mul_result = md_op[0] ? mul_prod[31:0] : mul_prod[63:32];

  // Restoring step: shift in the next dividend bit, subtract if it fits
  logic [32:0] div_trial;
  assign div_trial = {div_rem_q, div_quo_q[31]} - {1'b0, div_dvs_q};

  always_comb begin
    div_state_d = div_state_q;
    div_cnt_d   = div_cnt_q;
    div_rem_d   = div_rem_q;
    div_quo_d   = div_quo_q;
    div_dvs_d   = div_dvs_q;
    div_qneg_d  = div_qneg_q;
    div_rneg_d  = div_rneg_q;
    case (div_state_q)
      DIV_IDLE: begin
        if (es_valid_q && is_div) begin
          div_state_d = DIV_BUSY;
          div_cnt_d   = 5'd0;
          div_rem_d   = 32'd0;
          div_quo_d   = (is_signed_div && src1[31]) ? (32'd0 - src1) : src1;
          div_dvs_d   = (is_signed_div && src2[31]) ? (32'd0 - src2) : src2;
          div_qneg_d  = is_signed_div && (src1[31] ^ src2[31]);
          div_rneg_d  = is_signed_div && src1[31];
        end
      end
      DIV_BUSY: begin
        if (!div_trial[32]) begin
          div_rem_d = div_trial[31:0];
          div_quo_d = {div_quo_q[30:0], 1'b1};
        end else begin
          div_rem_d = {div_rem_q[30:0], div_quo_q[31]};
          div_quo_d = {div_quo_q[30:0], 1'b0};
        end
        div_cnt_d = div_cnt_q + 5'd1;
        if (div_cnt_q == 5'd31) div_state_d = DIV_DONE;
      end
      DIV_DONE: begin
        if (es_to_ms_valid && ms_allowin) div_state_d = DIV_IDLE;
      end
      default: div_state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      es_valid_q  <= 1'b0;
      bus_q       <= '0;
      div_state_q <= DIV_IDLE;
      div_cnt_q   <= 5'd0;
      div_rem_q   <= 32'd0;
      div_quo_q   <= 32'd0;
      div_dvs_q   <= 32'd0;
      div_qneg_q  <= 1'b0;
      div_rneg_q  <= 1'b0;
    end else begin
      es_valid_q  <= es_valid_d;
      bus_q       <= bus_d;
      div_state_q <= div_state_d;
      div_cnt_q   <= div_cnt_d;
      div_rem_q   <= div_rem_d;
      div_quo_q   <= div_quo_d;
      div_dvs_q   <= div_dvs_d;
      div_qneg_q  <= div_qneg_d;
      div_rneg_q  <= div_rneg_d;
    end
  end

  // A zero divisor leaves the raw remainder equal to |src1|, so the sign
  // fix-up alone restores src1; only the quotient needs forcing.
  logic [31:0] div_quo_fix, div_rem_fix, div_result, final_result;
  assign div_quo_fix  = (src2 == 32'd0) ? 32'hFFFF_FFFF
                      : (div_qneg_q ? (32'd0 - div_quo_q) : div_quo_q);
  assign div_rem_fix  = div_rneg_q ? (32'd0 - div_rem_q) : div_rem_q;
  assign div_result   = is_quo ? div_quo_fix : div_rem_fix;
  assign final_result = is_div ? div_result : (is_mul ? mul_result : alu_result);

  logic [3:0]  st_we;
  logic [31:0] st_wdata;
  always_comb begin
    st_we    = 4'b1111;
    st_wdata = rkd;
    if (ld_st_op[5]) begin
      st_we    = 4'b0001 << alu_result[1:0];
      st_wdata = {4{rkd[7:0]}};
    end else if (ld_st_op[6]) begin
      st_we    = alu_result[1] ? 4'b1100 : 4'b0011;
      st_wdata = {2{rkd[15:0]}};
    end
  end

  assign data_sram_en    = es_valid_q && (res_from_mem || mem_we);
  assign data_sram_we    = (es_valid_q && mem_we) ? st_we : 4'b0000;
  assign data_sram_addr  = alu_result;
  assign data_sram_wdata = st_wdata;

  assign es_to_ds_dest     = (es_valid_q && gr_we) ? dest : 5'd0;
  assign es_to_ds_value    = final_result;
  assign es_value_from_mem = es_valid_q && res_from_mem;

  assign es_to_ms_bus = {ld_st_op[4:0], alu_result[1:0], res_from_mem, gr_we,
                         dest, final_result, pc};

  logic unused_bits;
  assign unused_bits = ^{bus_q[DS_TO_ES_BUS_WD-1], mul_prod[65:64]};

endmodule

// Twelve-function ALU: add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui
module alu (
  input  logic [11:0] alu_op,
  input  logic [31:0] alu_src1,
  input  logic [31:0] alu_src2,
  output logic [31:0] alu_result
);

  logic        sub_like, slt_res, sltu_res;
  logic [32:0] adder;
  logic [31:0] sra_res;

  assign sub_like = alu_op[1] | alu_op[2] | alu_op[3];
  assign adder    = {1'b0, alu_src1} + {1'b0, (sub_like ? ~alu_src2 : alu_src2)}
                  + {32'd0, sub_like};
  assign slt_res  = (alu_src1[31] & ~alu_src2[31])
                  | (~(alu_src1[31] ^ alu_src2[31]) & adder[31]);
  assign sltu_res = ~adder[32];
  assign sra_res  = $signed(alu_src1) >>> alu_src2[4:0];

  assign alu_result = ({32{alu_op[0] | alu_op[1]}} & adder[31:0])
                    | ({32{alu_op[2]}}  & {31'd0, slt_res})
                    | ({32{alu_op[3]}}  & {31'd0, sltu_res})
                    | ({32{alu_op[4]}}  & (alu_src1 & alu_src2))
                    | ({32{alu_op[5]}}  & ~(alu_src1 | alu_src2))
                    | ({32{alu_op[6]}}  & (alu_src1 | alu_src2))
                    | ({32{alu_op[7]}}  & (alu_src1 ^ alu_src2))
                    | ({32{alu_op[8]}}  & (alu_src1 << alu_src2[4:0]))
                    | ({32{alu_op[9]}}  & (alu_src1 >> alu_src2[4:0]))
                    | ({32{alu_op[10]}} & sra_res)
                    | ({32{alu_op[11]}} & alu_src2);

endmodule

`default_nettype wire

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: directed vector table plus stall/reset sequences.
`default_nettype none

module tb_exe_stage;

  logic         clk = 1'b0;
  logic         reset, ms_allowin, ds_to_es_valid;
  logic [163:0] ds_to_es_bus;
  logic         es_allowin, es_to_ms_valid, es_value_from_mem, data_sram_en;
  logic [77:0]  es_to_ms_bus;
  logic [4:0]   es_to_ds_dest;
  logic [31:0]  es_to_ds_value, data_sram_addr, data_sram_wdata;
  logic [3:0]   data_sram_we;

  exe_stage dut (
    .clk               (clk),
    .reset             (reset),
    .ms_allowin        (ms_allowin),
    .es_allowin        (es_allowin),
    .ds_to_es_valid    (ds_to_es_valid),
    .ds_to_es_bus      (ds_to_es_bus),
    .es_to_ms_valid    (es_to_ms_valid),
    .es_to_ms_bus      (es_to_ms_bus),
    .es_to_ds_dest     (es_to_ds_dest),
    .es_to_ds_value    (es_to_ds_value),
    .es_value_from_mem (es_value_from_mem),
    .data_sram_en      (data_sram_en),
    .data_sram_we      (data_sram_we),
    .data_sram_addr    (data_sram_addr),
    .data_sram_wdata   (data_sram_wdata)
  );

  always #5 clk = ~clk;

  localparam logic [11:0] ADD   = 12'h001;
  localparam logic [11:0] SUB   = 12'h002;
  localparam logic [6:0]  MUL   = 7'h01;
  localparam logic [6:0]  MULH  = 7'h02;
  localparam logic [6:0]  MULHU = 7'h04;
  localparam logic [6:0]  DIVW  = 7'h08;
  localparam logic [6:0]  MODW  = 7'h10;
  localparam logic [6:0]  DIVU  = 7'h20;
  localparam logic [6:0]  MODU  = 7'h40;
  localparam logic [7:0]  LDW   = 8'h10;
  localparam logic [7:0]  STB   = 8'h20;
  localparam logic [7:0]  STH   = 8'h40;
  localparam logic [7:0]  STW   = 8'h80;

  typedef struct {
    logic [7:0]  ldst;
    logic [6:0]  md;
    logic [11:0] aop;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [31:0] rkd;
    logic        rfm;
    logic        mwe;
    logic        gwe;
    logic [4:0]  dest;
    logic [31:0] exp_res;
    int          exp_lat;
    logic [3:0]  exp_we;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [163:0] mkbus(input vec_t v, input logic [31:0] pc);
    return {1'b0, v.ldst, v.md, pc, v.aop, v.s1, v.s2, v.rkd, v.rfm, v.mwe, v.dest, v.gwe};
  endfunction

  // Called at a negedge; returns at the negedge where es_to_ms_valid is seen.
  task automatic run_op(input logic [163:0] bus, output int lat, output logic allow_low);
    ds_to_es_valid = 1'b1;
    ds_to_es_bus   = bus;
    @(negedge clk);
    ds_to_es_valid = 1'b0;
    lat       = 1;
    allow_low = 1'b1;
    while (!es_to_ms_valid && lat < 40) begin
      if (es_allowin) allow_low = 1'b0;
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic        allow_low;
    logic [31:0] pc;
    vec_t        v;

    //               ldst  md     aop  s1            s2            rkd           rfm  mwe  gwe  dest   exp_res       lat we       wdata
    vecs.push_back('{8'h0, 7'h0,  ADD, 32'd5,        32'd7,        32'd0,        1'b0,1'b0,1'b1,5'd3,  32'd12,       1,  4'h0,    32'h0});
    vecs.push_back('{8'h0, 7'h0,  SUB, 32'd5,        32'd7,        32'd0,        1'b0,1'b0,1'b1,5'd4,  32'hFFFFFFFE, 1,  4'h0,    32'h0});
    vecs.push_back('{8'h0, MUL,   12'h0,32'd3,       32'hFFFFFFFC, 32'd0,        1'b0,1'b0,1'b1,5'd5,  32'hFFFFFFF4, 1,  4'h0,    32'h0});
    vecs.push_back('{8'h0, MULH,  12'h0,32'hFFFFFFFF,32'hFFFFFFFF, 32'd0,        1'b0,1'b0,1'b1,5'd6,  32'h00000000, 1,  4'h0,    32'h0});
    vecs.push_back('{8'h0, MULHU, 12'h0,32'hFFFFFFFF,32'hFFFFFFFF, 32'd0,        1'b0,1'b0,1'b1,5'd7,  32'hFFFFFFFE, 1,  4'h0,    32'h0});
    vecs.push_back('{8'h0, DIVW,  12'h0,32'hFFFFFFF9,32'd2,        32'd0,        1'b0,1'b0,1'b1,5'd8,  32'hFFFFFFFD, 34, 4'h0,    32'h0});
    vecs.push_back('{8'h0, MODW,  12'h0,32'hFFFFFFF9,32'd2,        32'd0,        1'b0,1'b0,1'b1,5'd9,  32'hFFFFFFFF, 34, 4'h0,    32'h0});
    vecs.push_back('{8'h0, DIVW,  12'h0,32'd7,       32'hFFFFFFFE, 32'd0,        1'b0,1'b0,1'b1,5'd10, 32'hFFFFFFFD, 34, 4'h0,    32'h0});
    vecs.push_back('{8'h0, MODW,  12'h0,32'd7,       32'hFFFFFFFE, 32'd0,        1'b0,1'b0,1'b1,5'd11, 32'h00000001, 34, 4'h0,    32'h0});
    vecs.push_back('{8'h0, DIVU,  12'h0,32'h1234,    32'd0,        32'd0,        1'b0,1'b0,1'b1,5'd12, 32'hFFFFFFFF, 34, 4'h0,    32'h0});
    vecs.push_back('{8'h0, MODU,  12'h0,32'h1234,    32'd0,        32'd0,        1'b0,1'b0,1'b1,5'd13, 32'h00001234, 34, 4'h0,    32'h0});
    vecs.push_back('{8'h0, DIVW,  12'h0,32'h80000000,32'hFFFFFFFF, 32'd0,        1'b0,1'b0,1'b1,5'd14, 32'h80000000, 34, 4'h0,    32'h0});
    vecs.push_back('{8'h0, MODW,  12'h0,32'h80000000,32'hFFFFFFFF, 32'd0,        1'b0,1'b0,1'b1,5'd15, 32'h00000000, 34, 4'h0,    32'h0});
    vecs.push_back('{8'h0, DIVW,  12'h0,32'hFFFFFFF8,32'd0,        32'd0,        1'b0,1'b0,1'b1,5'd16, 32'hFFFFFFFF, 34, 4'h0,    32'h0});
    vecs.push_back('{8'h0, MODW,  12'h0,32'hFFFFFFF8,32'd0,        32'd0,        1'b0,1'b0,1'b1,5'd17, 32'hFFFFFFF8, 34, 4'h0,    32'h0});
    vecs.push_back('{8'h0, DIVU,  12'h0,32'd100,     32'd7,        32'd0,        1'b0,1'b0,1'b1,5'd18, 32'd14,       34, 4'h0,    32'h0});
    vecs.push_back('{8'h0, MODU,  12'h0,32'd100,     32'd7,        32'd0,        1'b0,1'b0,1'b1,5'd19, 32'd2,        34, 4'h0,    32'h0});
    vecs.push_back('{STB,  7'h0,  ADD, 32'h1000,     32'd3,        32'h000000AB, 1'b0,1'b1,1'b0,5'd0,  32'h1003,     1,  4'b1000, 32'hABABABAB});
    vecs.push_back('{STB,  7'h0,  ADD, 32'h1000,     32'd1,        32'h00000055, 1'b0,1'b1,1'b0,5'd0,  32'h1001,     1,  4'b0010, 32'h55555555});
    vecs.push_back('{STH,  7'h0,  ADD, 32'h1000,     32'd2,        32'h1234CDEF, 1'b0,1'b1,1'b0,5'd0,  32'h1002,     1,  4'b1100, 32'hCDEFCDEF});
    vecs.push_back('{STH,  7'h0,  ADD, 32'h1000,     32'd0,        32'h1234CDEF, 1'b0,1'b1,1'b0,5'd0,  32'h1000,     1,  4'b0011, 32'hCDEFCDEF});
    vecs.push_back('{STW,  7'h0,  ADD, 32'h1000,     32'd8,        32'hDEADBEEF, 1'b0,1'b1,1'b0,5'd0,  32'h1008,     1,  4'b1111, 32'hDEADBEEF});
    vecs.push_back('{LDW,  7'h0,  ADD, 32'h1000,     32'd4,        32'h0,        1'b1,1'b0,1'b1,5'd21, 32'h1004,     1,  4'b0000, 32'h0});

    reset          = 1'b1;
    ms_allowin     = 1'b1;
    ds_to_es_valid = 1'b0;
    ds_to_es_bus   = '0;
    repeat (3) @(negedge clk);
    check("reset es_to_ms_valid", {31'd0, es_to_ms_valid}, 32'd0);
    check("reset es_allowin", {31'd0, es_allowin}, 32'd1);
    check("reset es_to_ds_dest", {27'd0, es_to_ds_dest}, 32'd0);
    check("reset es_value_from_mem", {31'd0, es_value_from_mem}, 32'd0);
    check("reset data_sram_en", {31'd0, data_sram_en}, 32'd0);
    check("reset data_sram_we", {28'd0, data_sram_we}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle es_allowin", {31'd0, es_allowin}, 32'd1);

    for (int i = 0; i < vecs.size(); i++) begin
      v  = vecs[i];
      pc = 32'h1C00_0000 + 32'(i * 4);
      run_op(mkbus(v, pc), lat, allow_low);
      check($sformatf("v%0d latency", i), 32'(lat), 32'(v.exp_lat));
      check($sformatf("v%0d result", i), es_to_ms_bus[63:32], v.exp_res);
      check($sformatf("v%0d fwd value", i), es_to_ds_value, v.exp_res);
      check($sformatf("v%0d bus ctl", i), {20'd0, es_to_ms_bus[77:73], es_to_ms_bus[70:64]},
            {20'd0, v.ldst[4:0], v.rfm, v.gwe, v.dest});
      check($sformatf("v%0d bus pc", i), es_to_ms_bus[31:0], pc);
      check($sformatf("v%0d fwd dest", i), {27'd0, es_to_ds_dest}, {27'd0, (v.gwe ? v.dest : 5'd0)});
      check($sformatf("v%0d value_from_mem", i), {31'd0, es_value_from_mem}, {31'd0, v.rfm});
      check($sformatf("v%0d sram_en", i), {31'd0, data_sram_en}, {31'd0, (v.rfm | v.mwe)});
      check($sformatf("v%0d sram_we", i), {28'd0, data_sram_we}, {28'd0, v.exp_we});
      if (v.exp_lat > 1)
        check($sformatf("v%0d allowin low while busy", i), {31'd0, allow_low}, 32'd1);
      if (v.mwe)
        check($sformatf("v%0d sram_wdata", i), data_sram_wdata, v.exp_wdata);
      if (v.rfm | v.mwe) begin
        check($sformatf("v%0d sram_addr", i), data_sram_addr, v.exp_res);
        check($sformatf("v%0d bus addr lsb", i), {30'd0, es_to_ms_bus[72:71]}, {30'd0, v.exp_res[1:0]});
      end
    end

    // Divide finishing while the memory stage refuses it for 5 cycles
    @(negedge clk);
    ms_allowin = 1'b0;
    v = '{8'h0, DIVU, 12'h0, 32'd100, 32'd7, 32'd0, 1'b0, 1'b0, 1'b1, 5'd22, 32'd14, 34, 4'h0, 32'h0};
    run_op(mkbus(v, 32'h1C00_1000), lat, allow_low);
    check("stall latency", 32'(lat), 32'd34);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("stall%0d valid held", k), {31'd0, es_to_ms_valid}, 32'd1);
      check($sformatf("stall%0d result held", k), es_to_ms_bus[63:32], 32'd14);
      check($sformatf("stall%0d allowin", k), {31'd0, es_allowin}, 32'd0);
    end
    ms_allowin = 1'b1;
    @(negedge clk);
    check("stall release valid", {31'd0, es_to_ms_valid}, 32'd0);
    check("stall release allowin", {31'd0, es_allowin}, 32'd1);

    // Reset in the middle of a divide, then a fresh divide
    v = '{8'h0, DIVW, 12'h0, 32'hFFFFFFF9, 32'd2, 32'd0, 1'b0, 1'b0, 1'b1, 5'd23, 32'hFFFFFFFD, 34, 4'h0, 32'h0};
    ds_to_es_valid = 1'b1;
    ds_to_es_bus   = mkbus(v, 32'h1C00_2000);
    @(negedge clk);
    ds_to_es_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("busy fwd dest", {27'd0, es_to_ds_dest}, 32'd23);
    check("busy not valid", {31'd0, es_to_ms_valid}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset valid", {31'd0, es_to_ms_valid}, 32'd0);
    check("midreset allowin", {31'd0, es_allowin}, 32'd1);
    check("midreset fwd dest", {27'd0, es_to_ds_dest}, 32'd0);
    run_op(mkbus(v, 32'h1C00_2004), lat, allow_low);
    check("postreset latency", 32'(lat), 32'd34);
    check("postreset result", es_to_ms_bus[63:32], 32'hFFFFFFFD);
    check("postreset allowin low", {31'd0, allow_low}, 32'd1);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
